// File: rtl/axis_adc_spi_sampler.sv
// rtl/axis_adc_spi_sampler.sv - multi-channel SAR ADC SPI sampler with AXI-Stream output
//
// Purpose: drives a shared CONVST/SCK to NCH SAR ADCs at a programmable rate,
// deserialises all SDO lines in parallel, buffers whole sample sets in a FIFO
// and emits one AXI-Stream beat per channel, with TLAST on the last beat of
// every PKT_LEN-set packet. A set that does not fit in the FIFO is dropped
// whole and flagged on the sticky overflow output.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   sdo[NCH]       serial data, one line per ADC
//   sck            shared serial clock
//   convst         shared conversion start / chip select
//   din            held 1 (3-wire CS mode)
//   m_axis_*       output stream: tdata (sample), tuser (channel), tvalid,
//                  tready, tlast
//   overflow       sticky: a sample set was dropped
//
// Optional feature: define ADC_SIGN_EXT_EN to sign-extend samples into
// tdata[31:ADC_BITS]; otherwise those bits are zero.
module axis_adc_spi_sampler #(
  parameter int ADC_BITS   = 16,
  parameter int NCH        = 2,
  parameter int SAMPLE_DIV = 120,
  parameter int CONV_CYC   = 70,
  parameter int SCK_HALF   = 2,
  parameter int PKT_LEN    = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sdo,
  output logic           sck,
  output logic           convst,
  output logic           din,
  output logic [31:0]    m_axis_tdata,
  output logic [2:0]     m_axis_tuser,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tready,
  output logic           m_axis_tlast,
  output logic           overflow
);
  localparam int RW      = $clog2(SAMPLE_DIV + 1);
  localparam int CNT_MAX = (CONV_CYC > SCK_HALF) ? CONV_CYC : SCK_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(ADC_BITS + 1);
  localparam int SW      = $clog2(PKT_LEN + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int WW      = ADC_BITS + 4;

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, CHECK, PUSH} state_t;
  state_t state_q, state_d;

  logic [RW-1:0]       rate_cnt;
  logic                tick;
  logic [CW-1:0]       cnt;
  logic                phase;
  logic [BW-1:0]       bit_cnt;
  logic [2:0]          ch;
  logic [SW-1:0]       set_cnt;
  logic [ADC_BITS-1:0] shreg [NCH];
  logic                half_end, last_bit, last_ch;
  logic                fifo_wr, fifo_rd, drop;
  logic [WW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [ADC_BITS-1:0] push_sample;
  logic                push_last;
  logic [WW-1:0]       head;
  logic [31:0]         ext;

  // Registered tick: the first tick lands on the first cycle after reset
  // release, so convst rises one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rate_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (rate_cnt == '0);
      rate_cnt <= (rate_cnt == RW'(SAMPLE_DIV - 1)) ? '0 : rate_cnt + 1'b1;
    end
  end

  assign half_end = (cnt == CW'(SCK_HALF - 1));
  assign last_bit = (bit_cnt == BW'(ADC_BITS - 1));
  assign last_ch  = (ch == 3'(NCH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fifo_wr = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE:  if (tick) state_d = CONV;
      CONV:  if (cnt == CW'(CONV_CYC - 1)) state_d = SHIFT;
      SHIFT: if (half_end && phase && last_bit) state_d = CHECK;
      // Reserve room for the whole set up front so a partial set is never written.
      CHECK: begin
        if (count <= (AW+1)'(FIFO_DEPTH - NCH)) begin
          state_d = PUSH;
        end else begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      PUSH: begin
        fifo_wr = 1'b1;
        if (last_ch) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt times CONV and each SCK half-period; phase is the SCK level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      ch       <= '0;
      set_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      unique case (state_q)
        CONV: cnt <= (state_d == CONV) ? cnt + 1'b1 : '0;
        SHIFT: begin
          if (half_end) begin
            cnt   <= '0;
            phase <= ~phase;
            if (phase) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PUSH: begin
          if (last_ch) begin
            ch      <= '0;
            set_cnt <= (set_cnt == SW'(PKT_LEN - 1)) ? '0 : set_cnt + 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          ch      <= '0;
        end
      endcase
    end
  end

  // Capture on the edge where sck rises (end of the low phase), MSB first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) shreg[i] <= '0;
    end else if (state_q == SHIFT && half_end && !phase) begin
      for (int i = 0; i < NCH; i++) shreg[i] <= (shreg[i] << 1) | ADC_BITS'(sdo[i]);
    end
  end

  assign sck    = (state_q == SHIFT) && phase;
  assign convst = (state_q == CONV);
  assign din    = 1'b1;

  always_comb begin
    push_sample = shreg[0];
    for (int i = 1; i < NCH; i++) begin
      if (ch == 3'(i)) push_sample = shreg[i];
    end
  end

  assign push_last = last_ch && (set_cnt == SW'(PKT_LEN - 1));

  assign m_axis_tvalid = (count != '0);
  assign fifo_rd       = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {push_last, ch, push_sample};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
`ifdef ADC_SIGN_EXT_EN
    ext = {32{head[ADC_BITS-1]}};
`else
    ext = '0;
`endif
    ext[ADC_BITS-1:0] = head[ADC_BITS-1:0];
  end

  // Gate with tvalid so idle outputs read zero even though mem is not reset.
  assign m_axis_tdata = m_axis_tvalid ? ext : 32'd0;
  assign m_axis_tuser = m_axis_tvalid ? head[ADC_BITS+2:ADC_BITS] : 3'd0;
  assign m_axis_tlast = m_axis_tvalid && head[WW-1];
endmodule

// File: tb/tb_axis_adc_spi_sampler.sv
// tb/tb_axis_adc_spi_sampler.sv - scoreboard bench for axis_adc_spi_sampler
module tb_axis_adc_spi_sampler;
  localparam int ADC_BITS   = 16;
  localparam int NCH        = 2;
  localparam int SAMPLE_DIV = 120;
  localparam int CONV_CYC   = 40;
  localparam int SCK_HALF   = 2;
  localparam int PKT_LEN    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_NS     = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] sdo = '0;
  logic           sck, convst, din;
  logic [31:0]    tdata;
  logic [2:0]     tuser;
  logic           tvalid, tlast, overflow;
  logic           tready = 1'b0;

  always #(CLK_NS/2) clk = ~clk;

  axis_adc_spi_sampler #(
    .ADC_BITS(ADC_BITS), .NCH(NCH), .SAMPLE_DIV(SAMPLE_DIV), .CONV_CYC(CONV_CYC),
    .SCK_HALF(SCK_HALF), .PKT_LEN(PKT_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sdo(sdo), .sck(sck), .convst(convst), .din(din),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  user;
    logic        last;
  } beat_t;

  beat_t expq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_dec = 0;
  int    n_beats = 0;
  int    mset = 0;
  int    model_bit = -1;
  int    tr_mode = 1;
  logic  exp_ovf = 1'b0;
  bit    fixed_en = 1'b1;
  bit    prev_valid = 1'b0;
  time   prev_conv = 0;
  logic [ADC_BITS-1:0] fixed_val [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [ADC_BITS-1:0] v);
`ifdef ADC_SIGN_EXT_EN
    return v[ADC_BITS-1] ? ((32'hFFFF_FFFF << ADC_BITS) | 32'(v)) : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  // ADC model plus reference: bits leave MSB first and advance on each sck fall.
  // When a set completes, the expected beats are queued if the FIFO (as seen
  // by the scoreboard occupancy) has room for the whole set, else it is dropped.
  initial begin
    logic [ADC_BITS-1:0] cur [NCH];
    bit aborted;
    forever begin
      @(posedge convst);
      if (prev_valid) chk("tick_spacing", 32'(int'(($time - prev_conv) / CLK_NS)), SAMPLE_DIV);
      prev_conv  = $time;
      prev_valid = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        cur[c] = fixed_en ? fixed_val[c] : ADC_BITS'($urandom);
        sdo[c] = cur[c][ADC_BITS-1];
      end
      aborted = 1'b0;
      for (int b = ADC_BITS - 1; b >= 0; b--) begin
        model_bit = b;
        @(negedge sck or negedge rst);
        if (!rst) begin
          aborted = 1'b1;
          break;
        end
        if (b > 0) for (int c = 0; c < NCH; c++) sdo[c] = cur[c][b-1];
      end
      model_bit = -1;
      if (!aborted) begin
        n_dec++;
        if (FIFO_DEPTH - expq.size() >= NCH) begin
          for (int c = 0; c < NCH; c++)
            expq.push_back('{data: expand(cur[c]), user: 3'(c),
                             last: (c == NCH - 1) && (mset == PKT_LEN - 1)});
          mset = (mset + 1) % PKT_LEN;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: any presented beat must equal the scoreboard head, stalled or not.
  initial forever begin
    @(negedge clk);
    if (rst && tvalid) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h/%0d, none expected at %0t", tdata, tuser, $time);
      end else begin
        chk("tdata", tdata, expq[0].data);
        chk("tuser", 32'(tuser), 32'(expq[0].user));
        chk("tlast", 32'(tlast), 32'(expq[0].last));
        if (tready) begin
          void'(expq.pop_front());
          n_beats++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom);
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_dec(input int n);
    int target;
    int budget;
    target = n_dec + n;
    budget = n * SAMPLE_DIV * 3 + 300;
    while (n_dec < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (n_dec < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_sets: got %0d sets, want %0d", n_dec, target);
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 400;
    while (expq.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("drain", 32'(expq.size()), 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("convst_pre_tick", 32'(convst), 0);
    @(posedge clk);
    #1 chk("convst_rise", 32'(convst), 1);
  endtask

  initial begin
    int snap;
    int budget;
    fixed_val[0] = 16'hA5C3;
    fixed_val[1] = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", 32'(sck), 0);
    chk("rst_convst", 32'(convst), 0);
    chk("rst_din", 32'(din), 1);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", 32'(tuser), 0);
    chk("rst_overflow", 32'(overflow), 0);
    release_reset();

    // basic stream and framing: 8 sets, tlast on beats 8 and 16
    wait_dec(8);
    wait_drain();
    chk("basic_beats", 32'(n_beats), 16);

    // sign extension pattern
    fixed_val[0] = 16'h8001;
    fixed_val[1] = 16'h7FFF;
    wait_dec(2);
    wait_drain();

    // random data with random back-pressure
    fixed_en = 1'b0;
    tr_mode  = 2;
    wait_dec(10);
    tr_mode  = 1;
    wait_drain();
    chk("overflow_clear", 32'(overflow), 32'(exp_ovf));

    // back-pressure: 5 sets with the sink stalled, FIFO holds 2
    @(posedge clk);
    #1 tr_mode = 0;
    wait_dec(5);
    chk("overflow_set", 32'(overflow), 1);
    snap = n_beats;
    tr_mode = 1;
    repeat (20) @(posedge clk);
    #1 chk("bp_beats", 32'(n_beats - snap), 4);
    wait_drain();

    // reset while shifting bit 7
    fixed_en = 1'b1;
    fixed_val[0] = 16'hBEEF;
    fixed_val[1] = 16'h0F0F;
    budget = 400;
    while (model_bit != 7 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("reached_bit7", 32'(model_bit), 7);
    rst = 1'b0;
    expq.delete();
    mset = 0;
    exp_ovf = 1'b0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_convst", 32'(convst), 0);
    chk("rst_mid_sck", 32'(sck), 0);
    chk("rst_mid_tvalid", 32'(tvalid), 0);
    repeat (2) @(posedge clk);
    release_reset();
    chk("rst_mid_overflow", 32'(overflow), 0);
    wait_dec(2);
    wait_drain();

    chk("final_overflow", 32'(overflow), 32'(exp_ovf));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
